// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath sequencer: FSM states, instruction
// field positions and ALU opcodes. Optional build macro: SEQ_STEP_EN.
package datapath_sequencer_pkg;

    localparam int IW       = 10;
    localparam int HALT_BIT = 9;
    localparam int ALU_HI   = 8;
    localparam int ALU_LO   = 6;
    localparam int A3_HI    = 5;
    localparam int A3_LO    = 4;
    localparam int A1_HI    = 3;
    localparam int A1_LO    = 2;
    localparam int A2_HI    = 1;
    localparam int A2_LO    = 0;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;

`ifdef SEQ_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE,
        S_PAUSE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;
`endif

    function automatic logic is_halt(input logic [IW-1:0] ir);
        return ir[HALT_BIT];
    endfunction

endpackage

// File: rtl/datapath_sequencer_prog_mem.sv
// Program memory: DEPTH x 10 words, synchronous write, combinational read
// addressed by the program counter. Contents are deliberately not reset.
module seq_prog_mem
    import datapath_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PCW   = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [PCW-1:0] i_waddr,
    input  logic [IW-1:0]  i_wdata,
    input  logic [PCW-1:0] i_raddr,
    output logic [IW-1:0]  o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer feeding the datapath: fetch, decode, one write cycle
// per instruction. Define SEQ_STEP_EN to add single-step (step input, PAUSE).
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PCW   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [PCW-1:0] prog_addr,
    input  logic [9:0]     prog_data,
    input  logic           start,
`ifdef SEQ_STEP_EN
    input  logic           step,
`endif
    output logic           wr,
    output logic [1:0]     addr1,
    output logic [1:0]     addr2,
    output logic [1:0]     addr3,
    output logic [2:0]     ALUControl,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           done
);

    state_t         r_state;
    logic [PCW-1:0] r_pc;
    logic [IW-1:0]  r_ir;
    logic           r_busy;
    logic           r_done;

    logic           w_accept;
    logic           w_mem_we;
    logic [IW-1:0]  w_rdata;
    logic [PCW-1:0] w_pc_next;

    // Programming and start are only honoured while the sequencer is parked.
    assign w_accept  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_mem_we  = prog_we && w_accept;
    assign w_pc_next = r_pc + PCW'(1);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .PCW   (PCW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= w_rdata;
                    r_pc    <= w_pc_next;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // pc already advanced; a wrap to 0 is an implicit halt.
                    if (is_halt(r_ir) || (r_pc == '0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
`ifdef SEQ_STEP_EN
                        r_state <= S_PAUSE;
`else
                        r_state <= S_FETCH;
`endif
                    end
                end
`ifdef SEQ_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign wr         = (r_state == S_EXEC) && !is_halt(r_ir);
    assign ALUControl = r_ir[ALU_HI:ALU_LO];
    assign addr3      = r_ir[A3_HI:A3_LO];
    assign addr1      = r_ir[A1_HI:A1_LO];
    assign addr2      = r_ir[A2_HI:A2_LO];
    assign pc         = r_pc;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer driving a small 4x8 register-file datapath.
// Build with SEQ_STEP_EN to exercise single-step.
module tb_datapath_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [9:0] prog_data = '0;
    logic       start = 1'b0;
    logic       step = 1'b1;
    logic       wr;
    logic [1:0] addr1, addr2, addr3;
    logic [2:0] ALUControl;
    logic [3:0] pc;
    logic       busy, done;

    logic       we4 = 1'b0;
    logic [1:0] pa4 = '0;
    logic       start4 = 1'b0;
    logic       wr4;
    logic [1:0] a1_4, a2_4, a3_4;
    logic [2:0] alu4;
    logic [1:0] pc4;
    logic       busy4, done4;

    always #5 clk = ~clk;

`ifdef SEQ_STEP_EN
    localparam int SP = 3;
`else
    localparam int SP = 2;
`endif

    datapath_sequencer #(.DEPTH(16), .PCW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .wr         (wr),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .ALUControl (ALUControl),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    datapath_sequencer #(.DEPTH(4), .PCW(2)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (we4),
        .prog_addr  (pa4),
        .prog_data  (prog_data),
        .start      (start4),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .wr         (wr4),
        .addr1      (a1_4),
        .addr2      (a2_4),
        .addr3      (a3_4),
        .ALUControl (alu4),
        .pc         (pc4),
        .busy       (busy4),
        .done       (done4)
    );

    // Downstream datapath: 4 x 8-bit registers, ADD/SUB/AND.
    logic [7:0] rf [4];
    logic [7:0] alu_y;

    always_comb begin
        alu_y = 8'h00;
        case (ALUControl)
            3'b000:  alu_y = rf[addr1] + rf[addr2];
            3'b001:  alu_y = rf[addr1] - rf[addr2];
            3'b010:  alu_y = rf[addr1] & rf[addr2];
            default: alu_y = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf[0] <= 8'h00;
            rf[1] <= 8'h05;
            rf[2] <= 8'hFF;
            rf[3] <= 8'h07;
        end else if (wr) begin
            rf[addr3] <= alu_y;
        end
    end

    typedef struct {
        logic [9:0] word;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        logic [2:0] alu;
    } vec_t;

    typedef struct {
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        logic [2:0] alu;
        int         cyc;
    } exp_t;

    vec_t prog [5];
    exp_t sb [$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_main;
        for (int i = 0; i < 5; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = prog[i].word;
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int k, input bit inj, input int rst_at);
        exp_t e;
        int   c;
        bit   fin;
        logic prev;
        for (int i = 0; i < k; i++) begin
            e.a1  = prog[i].a1;
            e.a2  = prog[i].a2;
            e.a3  = prog[i].a3;
            e.alu = prog[i].alu;
            e.cyc = 2 + SP * i;
            sb.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        fin = 1'b0;
        prev = 1'b0;
        while (!fin && c < 80) begin
            if (c == 1) begin
                check("busy_fetch", 32'(busy), 1);
                check("done_clr", 32'(done), 0);
            end
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_outs", 32'({wr, busy, done, pc, addr1, addr2,
                                       addr3, ALUControl}), 0);
                sb.delete();
                #2 rst = 1'b0;
                fin = 1'b1;
            end else begin
                if (wr) begin
                    check("wr_gap", 32'(prev), 0);
                    if (sb.size() == 0) begin
                        check("wr_extra", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("wr_cyc", 32'(c), 32'(e.cyc));
                        check("wr_fields",
                              32'({addr1, addr2, addr3, ALUControl}),
                              32'({e.a1, e.a2, e.a3, e.alu}));
                    end
                end
                prev = wr;
                if (done) begin
                    check("done_cyc", 32'(c), 32'(3 + SP * k));
                    check("sb_empty", 32'(sb.size()), 0);
                    check("busy_done", 32'(busy), 0);
                    check("pc_done", 32'(pc), 32'(k + 1));
                    fin = 1'b1;
                end
                if (inj && c == 5) begin
                    prog_we   = 1'b1;
                    prog_addr = 4'd1;
                    prog_data = 10'h3FF;
                    start     = 1'b1;
                end
                if (!fin) begin
                    tick();
                    c++;
                    prog_we = 1'b0;
                    start   = 1'b0;
                end
            end
        end
        if (!fin) check("run_timeout", 0, 1);
    endtask

    task automatic check_rf;
        check("R0", 32'(rf[0]), 32'h0FF);
        check("R1", 32'(rf[1]), 32'h000);
        check("R2", 32'(rf[2]), 32'h0FF);
        check("R3", 32'(rf[3]), 32'h000);
    endtask

    initial begin
        int  n;
        int  c;
        bit  fin;
        bit  stray;
        logic [1:0] last3;

        prog[0] = '{10'h055, 2'd1, 2'd1, 2'd1, 3'b001};
        prog[1] = '{10'h08A, 2'd2, 2'd2, 2'd0, 3'b010};
        prog[2] = '{10'h024, 2'd1, 2'd0, 2'd2, 3'b000};
        prog[3] = '{10'h070, 2'd0, 2'd0, 2'd3, 3'b001};
        prog[4] = '{10'h200, 2'd0, 2'd0, 2'd0, 3'b000};

        tick();
        tick();
        check("reset_outs", 32'({wr, busy, done, pc, addr1, addr2, addr3,
                                 ALUControl}), 0);
        rst = 1'b0;
        tick();

        load_main();
        run_prog(4, 1'b0, 0);
        check_rf();
        run_prog(4, 1'b1, 0);
        run_prog(4, 1'b0, 2 + SP);
        tick();
        run_prog(4, 1'b0, 0);
        check_rf();

        // DEPTH=4 instance, no halt word: end of memory halts.
        for (int i = 0; i < 4; i++) begin
            we4       = 1'b1;
            pa4       = 2'(i);
            prog_data = prog[i].word;
            tick();
        end
        we4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        fin = 1'b0;
        last3 = '0;
        for (c = 1; c < 60 && !fin; c++) begin
            if (wr4) begin
                n++;
                last3 = a3_4;
            end
            if (done4) begin
                check("wrap_done_cyc", 32'(c), 32'(3 + SP * 3));
                check("wrap_wr_cnt", 32'(n), 4);
                check("wrap_pc", 32'(pc4), 0);
                check("wrap_last_a3", 32'(last3), 3);
                fin = 1'b1;
            end else begin
                tick();
            end
        end
        if (!fin) check("wrap_timeout", 0, 1);

`ifdef SEQ_STEP_EN
        step = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("step_first_wr", 32'(wr), 1);
        stray = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (wr) stray = 1'b1;
        end
        check("step_hold", 32'(stray), 0);
        check("step_pc", 32'(pc), 1);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check("step_fetch_wr", 32'(wr), 0);
            tick();
            check("step_exec_wr", 32'(wr), 1);
            check("step_a3", 32'(addr3), 32'(prog[s + 1].a3));
            tick();
            check("step_pause_wr", 32'(wr), 0);
        end
        step = 1'b1;
        fin = 1'b0;
        for (int j = 0; j < 20 && !fin; j++) begin
            if (done) fin = 1'b1;
            else tick();
        end
        check("step_done", 32'(fin), 1);
`endif

        // Immediate halt at PC 0.
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 10'h200;
        tick();
        prog_we = 1'b0;
        run_prog(0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
